// File: rtl/seven_seg_digit_driver.sv
// seven_seg_digit_driver: drives active-low cathode/dp for the digit that the
// scanner's one-cold anode vector selects. Display value is double-buffered:
// loads land in a shadow and commit on the wrap into digit 0, so a frame never
// mixes old and new digits.
// Optional macro SEG_DIM_EN adds a brightness input and a 3-bit PWM that
// gates anode_out.
module seven_seg_digit_driver #(
    parameter int         DIGITS        = 4,
    parameter logic [6:0] BLANK_PATTERN = 7'h7F
) (
    input  logic                  clock,
    input  logic                  reset,
`ifdef SEG_DIM_EN
    input  logic [2:0]            brightness,
`endif
    input  logic [DIGITS-1:0]     anode,
    input  logic [4*DIGITS-1:0]   value_in,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic                  load,
    input  logic                  blank_lz,
    output logic [6:0]            cathode,
    output logic                  dp,
    output logic [DIGITS-1:0]     anode_out,
    output logic                  pending,
    output logic                  frame_done
);

    localparam int SW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [DIGITS-1:0] D0_CODE  = {{(DIGITS-1){1'b1}}, 1'b0};
    localparam logic [DIGITS-1:0] ALL_ONES = '1;

    logic [DIGITS-1:0][3:0] active, shadow;
    logic [DIGITS-1:0]      active_dp, shadow_dp;
    logic [DIGITS-1:0]      prev_anode;
    logic [SW-1:0]          sel;
    logic [3:0]             low_cnt;
    logic                   anode_valid;
    logic                   commit;
    logic [DIGITS-1:0]      zero_above;
    logic                   blank_sel;
    logic [DIGITS-1:0]      dim_mask;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
        case (h)
            4'h0: return 7'h40;  4'h1: return 7'h79;
            4'h2: return 7'h24;  4'h3: return 7'h30;
            4'h4: return 7'h19;  4'h5: return 7'h12;
            4'h6: return 7'h02;  4'h7: return 7'h78;
            4'h8: return 7'h00;  4'h9: return 7'h10;
            4'hA: return 7'h08;  4'hB: return 7'h03;
            4'hC: return 7'h46;  4'hD: return 7'h21;
            4'hE: return 7'h06;  default: return 7'h0E;
        endcase
    endfunction

    // Locate the selected digit and count low anode bits; exactly one low is valid.
    always_comb begin
        low_cnt = '0;
        sel     = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (!anode[i]) begin
                low_cnt = low_cnt + 4'd1;
                sel     = SW'(i);
            end
        end
        anode_valid = (low_cnt == 4'd1);
    end

    // zero_above[i]: nibbles i..DIGITS-1 of the active value are all zero.
    always_comb begin
        zero_above = '0;
        zero_above[DIGITS-1] = (active[DIGITS-1] == 4'h0);
        for (int i = DIGITS - 2; i >= 0; i--)
            zero_above[i] = zero_above[i+1] && (active[i] == 4'h0);
    end

    assign blank_sel = blank_lz && (sel != '0) && zero_above[sel];
    assign commit    = (anode == D0_CODE) && (prev_anode != D0_CODE);

`ifdef SEG_DIM_EN
    logic [2:0] pwm_cnt;

    // Free-running PWM phase; independent of scan and commit timing.
    always_ff @(posedge clock) begin
        if (reset) pwm_cnt <= '0;
        else       pwm_cnt <= pwm_cnt + 3'd1;
    end

    assign dim_mask = (pwm_cnt >= brightness) ? ALL_ONES : '0;
`else
    assign dim_mask = '0;
`endif

    // Shadow capture and frame-boundary commit; a load on the commit cycle
    // commits the old shadow and keeps the new one pending.
    always_ff @(posedge clock) begin
        if (reset) begin
            active     <= '0;
            active_dp  <= '0;
            shadow     <= '0;
            shadow_dp  <= '0;
            pending    <= 1'b0;
            frame_done <= 1'b0;
            prev_anode <= ALL_ONES;
        end else begin
            prev_anode <= anode;
            frame_done <= commit && pending;
            if (commit && pending) begin
                active    <= shadow;
                active_dp <= shadow_dp;
            end
            if (load) begin
                shadow    <= value_in;
                shadow_dp <= dp_in;
                pending   <= 1'b1;
            end else if (commit) begin
                pending   <= 1'b0;
            end
        end
    end

    // Single output register stage: segments, dp and anode aligned.
    always_ff @(posedge clock) begin
        if (reset) begin
            cathode   <= BLANK_PATTERN;
            dp        <= 1'b1;
            anode_out <= ALL_ONES;
        end else if (anode_valid) begin
            cathode   <= blank_sel ? BLANK_PATTERN : hex_to_seg(active[sel]);
            dp        <= ~active_dp[sel];
            anode_out <= anode | dim_mask;
        end else begin
            cathode   <= BLANK_PATTERN;
            dp        <= 1'b1;
            anode_out <= ALL_ONES;
        end
    end

endmodule

// File: tb/tb_seven_seg_digit_driver.sv
// Bench for seven_seg_digit_driver: directed steps plus randomized scanning,
// every cycle compared against a behavioural model of the display rules.
module tb_seven_seg_digit_driver;

    localparam int N = 4;

    logic           clock = 1'b0;
    logic           reset;
    logic [N-1:0]   anode;
    logic [4*N-1:0] value_in;
    logic [N-1:0]   dp_in;
    logic           load;
    logic           blank_lz;
    logic [6:0]     cathode;
    logic           dp;
    logic [N-1:0]   anode_out;
    logic           pending;
    logic           frame_done;
`ifdef SEG_DIM_EN
    logic [2:0]     brightness = 3'd7;
`endif

    seven_seg_digit_driver #(.DIGITS(N), .BLANK_PATTERN(7'h7F)) dut (
        .clock(clock), .reset(reset),
`ifdef SEG_DIM_EN
        .brightness(brightness),
`endif
        .anode(anode), .value_in(value_in), .dp_in(dp_in), .load(load),
        .blank_lz(blank_lz), .cathode(cathode), .dp(dp), .anode_out(anode_out),
        .pending(pending), .frame_done(frame_done)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int failures = 0;

    logic [6:0] seg_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    // model state
    logic [4*N-1:0] m_active, m_shadow;
    logic [N-1:0]   m_adp, m_sdp, m_prev;
    logic           m_pend;
    logic [6:0]     e_cath;
    logic           e_dp, e_fd;
    logic [N-1:0]   e_an;
    int             m_cnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance the model by one clock edge using the inputs that were present.
    task automatic model_edge();
        int  idx;
        int  upper;
        bit  commit, valid, blank;
        if (reset) begin
            m_active = '0; m_shadow = '0; m_adp = '0; m_sdp = '0;
            m_pend = 0; m_prev = '1; m_cnt = 0;
            e_cath = 7'h7F; e_dp = 1; e_an = '1; e_fd = 0;
            return;
        end
        valid = ($countones(~anode) == 1);
        if (valid) begin
            idx = 0;
            for (int i = 0; i < N; i++) if (!anode[i]) idx = i;
            upper = int'(m_active >> (4 * idx));
            blank = blank_lz && idx != 0 && upper == 0;
            e_cath = blank ? 7'h7F : seg_tbl[upper % 16];
            e_dp   = !m_adp[idx];
            e_an   = anode;
`ifdef SEG_DIM_EN
            if (m_cnt >= int'(brightness)) e_an = '1;
`endif
        end else begin
            e_cath = 7'h7F; e_dp = 1; e_an = '1;
        end
        m_cnt  = (m_cnt + 1) % 8;
        commit = (anode == 4'b1110) && (m_prev != 4'b1110);
        e_fd   = commit && m_pend;
        if (e_fd) begin m_active = m_shadow; m_adp = m_sdp; end
        if (load) begin m_shadow = value_in; m_sdp = dp_in; m_pend = 1; end
        else if (commit) m_pend = 0;
        m_prev = anode;
    endtask

    task automatic step();
        @(posedge clock);
        model_edge();
        #1;
        check("cathode", 32'(cathode), 32'(e_cath));
        check("dp", 32'(dp), 32'(e_dp));
        check("anode_out", 32'(anode_out), 32'(e_an));
        check("pending", 32'(pending), 32'(m_pend));
        check("frame_done", 32'(frame_done), 32'(e_fd));
        load = 0;
    endtask

    task automatic scan_to(input logic [N-1:0] a);
        anode = a;
        step();
    endtask

    initial begin
        int ptr;
        int lit;
        logic [15:0] mask;
        reset = 1; anode = '1; value_in = '0; dp_in = '0; load = 0; blank_lz = 0;
        step(); step();
        check("rst_cathode", 32'(cathode), 32'h7F);
        check("rst_pending", 32'(pending), 32'h0);
        reset = 0;

        // first digit after reset shows 0
        scan_to(4'b1110);
        check("d0_zero", 32'(cathode), 32'h40);
        check("d0_dp", 32'(dp), 32'h1);
        check("d0_anode", 32'(anode_out), 32'hE);
        check("d0_pend", 32'(pending), 32'h0);

        // load 12AF, commit on wrap
        value_in = 16'h12AF; dp_in = 4'b0100; load = 1;
        scan_to(4'b0111);
        check("load_pend", 32'(pending), 32'h1);
        scan_to(4'b1011); scan_to(4'b1101);
        check("hold_pend", 32'(pending), 32'h1);
        scan_to(4'b1110);
        check("commit_fd", 32'(frame_done), 32'h1);
        check("commit_pend", 32'(pending), 32'h0);
        scan_to(4'b0111);
        check("dig3", 32'(cathode), 32'h79);
        check("fd_once", 32'(frame_done), 32'h0);
        scan_to(4'b1011);
        check("dig2", 32'(cathode), 32'h24);
        check("dig2_dp", 32'(dp), 32'h0);
        scan_to(4'b1101);
        check("dig1", 32'(cathode), 32'h08);
        scan_to(4'b1110);
        check("dig0", 32'(cathode), 32'h0E);
        check("no_fd", 32'(frame_done), 32'h0);

        // leading-zero blanking
        blank_lz = 1; value_in = 16'h0005; dp_in = '0; load = 1;
        scan_to(4'b0111); scan_to(4'b1011); scan_to(4'b1101); scan_to(4'b1110);
        scan_to(4'b0111); check("lz3", 32'(cathode), 32'h7F);
        scan_to(4'b1011); check("lz2", 32'(cathode), 32'h7F);
        scan_to(4'b1101); check("lz1", 32'(cathode), 32'h7F);
        scan_to(4'b1110); check("lz0", 32'(cathode), 32'h12);
        value_in = 16'h0000; load = 1;
        scan_to(4'b0111); scan_to(4'b1011); scan_to(4'b1101); scan_to(4'b1110);
        scan_to(4'b0111); check("lz_all3", 32'(cathode), 32'h7F);
        scan_to(4'b1011); scan_to(4'b1101);
        scan_to(4'b1110); check("lz_zero0", 32'(cathode), 32'h40);
        blank_lz = 0;

        // latest load wins
        value_in = 16'h1111; load = 1; scan_to(4'b0111);
        value_in = 16'h2222; load = 1; scan_to(4'b1011);
        scan_to(4'b1101);
        scan_to(4'b1110); check("two_fd", 32'(frame_done), 32'h1);
        scan_to(4'b0111); check("two_val", 32'(cathode), 32'h24);

        // load on the commit cycle
        value_in = 16'h3333; load = 1; scan_to(4'b1011);
        scan_to(4'b1101);
        value_in = 16'h4444; load = 1; scan_to(4'b1110);
        check("lc_fd", 32'(frame_done), 32'h1);
        check("lc_pend", 32'(pending), 32'h1);
        scan_to(4'b0111); check("lc_old", 32'(cathode), 32'h30);
        scan_to(4'b1011); scan_to(4'b1101); scan_to(4'b1110);
        check("lc_fd2", 32'(frame_done), 32'h1);
        scan_to(4'b0111); check("lc_new", 32'(cathode), 32'h19);

        // invalid anodes
        scan_to(4'b1111);
        check("inv_cath", 32'(cathode), 32'h7F);
        check("inv_an", 32'(anode_out), 32'hF);
        scan_to(4'b1100);
        check("inv2_cath", 32'(cathode), 32'h7F);
        check("inv2_an", 32'(anode_out), 32'hF);
        check("inv2_fd", 32'(frame_done), 32'h0);

        // randomized scanning with loads, invalid codes and resets
        ptr = 3;
        for (int c = 0; c < 600; c++) begin
            case ($urandom_range(0, 3))
                0: mask = 16'hFFFF;
                1: mask = 16'h00FF;
                2: mask = 16'h000F;
                default: mask = 16'h0000;
            endcase
            value_in = 16'($urandom) & mask;
            dp_in    = 4'($urandom);
            load     = ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 15) == 0) blank_lz = ~blank_lz;
            reset    = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 9) == 0) begin
                anode = 4'($urandom);
            end else begin
                anode = ~(4'b0001 << ptr);
                ptr = (ptr == 0) ? 3 : ptr - 1;
            end
            step();
        end
        reset = 0;

`ifdef SEG_DIM_EN
        brightness = 3'd2; anode = 4'b1110;
        step();
        lit = 0;
        for (int c = 0; c < 8; c++) begin
            step();
            if (anode_out == 4'b1110) lit++;
        end
        check("dim_lit", 32'(lit), 32'd2);
`else
        lit = 0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
